// File: rtl/oss_hal_reg_arbiter.sv
// Round-robin arbiter sharing one HAL register port between NUM_REQ requesters.
// One transaction in flight; write/read strobes are single-cycle, read data returned with a one-cycle ack.
module oss_hal_reg_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 1,
    localparam int IDW         = $clog2(NUM_REQ)
) (
    input  logic                  hal_clk,
    input  logic                  hal_reset,
    input  logic [NUM_REQ-1:0]    req_valid_in,
    input  logic [NUM_REQ-1:0]    req_write_in,
    input  logic [4*NUM_REQ-1:0]  req_addr_in,
    input  logic [32*NUM_REQ-1:0] req_wdata_in,
    output logic [NUM_REQ-1:0]    req_ack_out,
    output logic [31:0]           req_rdata_out,
    output logic [IDW-1:0]        grant_id_out,
    output logic                  busy_out,
    output logic                  reg_itf_write_out,
    output logic                  reg_itf_read_out,
    output logic [3:0]            reg_itf_addr_out,
    output logic [31:0]           reg_itf_writedata_out,
    input  logic [31:0]           reg_itf_readdata_in
);

    localparam int CNTW = $clog2(READ_LATENCY + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic            wr_q, wr_d;
    logic [3:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [3:0]      addr_arr  [NUM_REQ];
    logic [31:0]     wdata_arr [NUM_REQ];
    logic            win_found;
    logic [IDW-1:0]  win_id;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr_in[4*i +: 4];
            wdata_arr[i] = req_wdata_in[32*i +: 32];
        end
    end

    // First valid requester after the last winner, wrapping around.
    always_comb begin
        logic [IDW-1:0] sel;
        win_found = 1'b0;
        win_id    = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sel = IDW'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && req_valid_in[sel]) begin
                win_found = 1'b1;
                win_id    = sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ISSUE;
                    last_d  = win_id;
                    grant_d = win_id;
                    wr_d    = req_write_in[win_id];
                    addr_d  = addr_arr[win_id];
                    wdata_d = wdata_arr[win_id];
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNTW'(READ_LATENCY);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Slave data is valid in the last WAIT cycle only.
                if (cnt_q == CNTW'(1)) begin
                    rdata_d = reg_itf_readdata_in;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hal_clk) begin
        if (hal_reset) begin
            state_q <= IDLE;
            last_q  <= IDW'(NUM_REQ - 1);
            grant_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        req_ack_out = '0;
        if (state_q == ACK) req_ack_out[grant_q] = 1'b1;
    end

    assign req_rdata_out         = rdata_q;
    assign grant_id_out          = grant_q;
    assign busy_out              = (state_q != IDLE);
    assign reg_itf_write_out     = (state_q == ISSUE) && wr_q;
    assign reg_itf_read_out      = (state_q == ISSUE) && !wr_q;
    assign reg_itf_addr_out      = addr_q;
    assign reg_itf_writedata_out = wdata_q;

endmodule

// File: tb/tb_oss_hal_reg_arbiter.sv
// Scoreboard bench: instance A (READ_LATENCY=1) against an adder-style slave, instance B (READ_LATENCY=3) for reset-in-WAIT.
module tb_oss_hal_reg_arbiter;

    typedef struct {
        int          id;
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb_q[$];
    txn_t hal_q[$];
    int   errs   = 0;
    int   checks = 0;

    logic        hal_clk;
    logic        rst_a, rst_b;
    logic [1:0]  valid_a, write_a, valid_b, write_b;
    logic [7:0]  addr_a, addr_b;
    logic [63:0] wdata_a, wdata_b;
    logic [1:0]  ack_a, ack_b;
    logic [31:0] rdata_a, rdata_b;
    logic        grant_a, grant_b, busy_a, busy_b;
    logic        wr_a, rd_a, wr_b, rd_b;
    logic [3:0]  haddr_a, haddr_b;
    logic [31:0] hwdata_a, hwdata_b, hrdata_a, hrdata_b;

    oss_hal_reg_arbiter #(.NUM_REQ(2), .READ_LATENCY(1)) dut_a (
        .hal_clk(hal_clk), .hal_reset(rst_a),
        .req_valid_in(valid_a), .req_write_in(write_a), .req_addr_in(addr_a), .req_wdata_in(wdata_a),
        .req_ack_out(ack_a), .req_rdata_out(rdata_a), .grant_id_out(grant_a), .busy_out(busy_a),
        .reg_itf_write_out(wr_a), .reg_itf_read_out(rd_a), .reg_itf_addr_out(haddr_a),
        .reg_itf_writedata_out(hwdata_a), .reg_itf_readdata_in(hrdata_a)
    );

    oss_hal_reg_arbiter #(.NUM_REQ(2), .READ_LATENCY(3)) dut_b (
        .hal_clk(hal_clk), .hal_reset(rst_b),
        .req_valid_in(valid_b), .req_write_in(write_b), .req_addr_in(addr_b), .req_wdata_in(wdata_b),
        .req_ack_out(ack_b), .req_rdata_out(rdata_b), .grant_id_out(grant_b), .busy_out(busy_b),
        .reg_itf_write_out(wr_b), .reg_itf_read_out(rd_b), .reg_itf_addr_out(haddr_b),
        .reg_itf_writedata_out(hwdata_b), .reg_itf_readdata_in(hrdata_b)
    );

    initial begin
        hal_clk = 1'b0;
        forever #5 hal_clk = ~hal_clk;
    end

    // Slave A: addr0 = a, addr1 = b, addr2 reads a+b; data valid exactly one cycle after the read pulse.
    logic [31:0] sa = 32'h0, sb = 32'h0, rd_data_a = 32'h0;
    logic        rv_a = 1'b0;
    always @(posedge hal_clk) begin
        if (wr_a && haddr_a == 4'd0) sa <= hwdata_a;
        if (wr_a && haddr_a == 4'd1) sb <= hwdata_a;
        rv_a      <= rd_a;
        rd_data_a <= (haddr_a == 4'd2) ? sa + sb : (haddr_a == 4'd0) ? sa : (haddr_a == 4'd1) ? sb : 32'h0;
    end
    assign hrdata_a = rv_a ? rd_data_a : 32'hDEAD_BEEF;

    // Slave B: returns 0x0ABC123<addr> exactly three cycles after the read pulse.
    logic [2:0]  rv_b = 3'b0;
    logic [31:0] rdb [3];
    always @(posedge hal_clk) begin
        rv_b   <= {rv_b[1:0], rd_b};
        rdb[0] <= {28'h0ABC123, haddr_b};
        rdb[1] <= rdb[0];
        rdb[2] <= rdb[1];
    end
    assign hrdata_b = rv_b[2] ? rdb[2] : 32'hDEAD_BEEF;

    // Scoreboard monitor for instance A: HAL strobes and acks checked against expected queues.
    initial begin
        bit          prev;
        txn_t        t;
        logic [1:0]  e;
        prev = 1'b0;
        forever begin
            @(negedge hal_clk);
            if (rst_a) begin
                prev = 1'b0;
            end else begin
                if (wr_a || rd_a) begin
                    checks++;
                    if ((wr_a && rd_a) || prev) begin
                        errs++;
                        $display("FAIL pulse_shape: write=%0b read=%0b prev_pulse=%0b, required one strobe not following another", wr_a, rd_a, prev);
                    end
                    checks++;
                    if (hal_q.size() == 0) begin
                        errs++;
                        $display("FAIL hal_unexpected: write=%0b addr=%0h, required no strobe", wr_a, haddr_a);
                    end else begin
                        t = hal_q.pop_front();
                        if (wr_a !== t.wr || haddr_a !== t.addr || (t.wr && hwdata_a !== t.data)) begin
                            errs++;
                            $display("FAIL hal_cmd: wr=%0b addr=%0h data=%0h, required wr=%0b addr=%0h data=%0h",
                                     wr_a, haddr_a, hwdata_a, t.wr, t.addr, t.data);
                        end
                    end
                end
                prev = wr_a || rd_a;
                if (ack_a != 2'b00) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errs++;
                        $display("FAIL ack_unexpected: ack=%b, required 00", ack_a);
                    end else begin
                        t = sb_q.pop_front();
                        e = 2'b00;
                        e[t.id] = 1'b1;
                        if (ack_a !== e || grant_a !== t.id[0] || (!t.wr && rdata_a !== t.rdata)) begin
                            errs++;
                            $display("FAIL ack_txn: ack=%b grant=%0d rdata=%0h, required ack=%b grant=%0d rdata=%0h",
                                     ack_a, grant_a, rdata_a, e, t.id, t.rdata);
                        end
                    end
                end
            end
        end
    end

    task automatic set_req(input int id, input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [31:0] rd);
        txn_t t;
        write_a[id]        = wr;
        addr_a[4*id +: 4]  = a;
        wdata_a[32*id +: 32] = d;
        t.id = id; t.wr = wr; t.addr = a; t.data = d; t.rdata = rd;
        sb_q.push_back(t);
        hal_q.push_back(t);
    endtask

    // Waits for ack_a[id]; lat = posedges since call, or -1 if the bound expires.
    task automatic wait_ack_a(input int id, output int lat);
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge hal_clk);
            @(negedge hal_clk);
            if (ack_a[id]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic wait_ack_b(output int lat);
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge hal_clk);
            @(negedge hal_clk);
            if (ack_b[0]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_txn(input int id, input bit wr, input logic [3:0] a, input logic [31:0] d,
                           input logic [31:0] rd, output int lat);
        set_req(id, wr, a, d, rd);
        valid_a[id] = 1'b1;
        wait_ack_a(id, lat);
        valid_a[id] = 1'b0;
        @(negedge hal_clk);
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = '0; write_a = '0; addr_a = '0; wdata_a = '0;
        valid_b = '0; write_b = '0; addr_b = '0; wdata_b = '0;
        repeat (3) @(posedge hal_clk);
        @(negedge hal_clk);
        checks++;
        if (ack_a !== 2'b00 || busy_a !== 1'b0 || grant_a !== 1'b0 || wr_a !== 1'b0 || rd_a !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctrl: ack=%b busy=%b grant=%b wr=%b rd=%b, required all 0", ack_a, busy_a, grant_a, wr_a, rd_a);
        end
        checks++;
        if (haddr_a !== 4'h0 || hwdata_a !== 32'h0 || rdata_a !== 32'h0) begin
            errs++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required all 0", haddr_a, hwdata_a, rdata_a);
        end
        checks++;
        if (busy_b !== 1'b0 || rdata_b !== 32'h0) begin
            errs++;
            $display("FAIL reset_b: busy=%b rdata=%h, required 0/0", busy_b, rdata_b);
        end
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_write;
        int lat;
        run_txn(0, 1'b1, 4'd0, 32'h5, 32'h0, lat);
        checks++;
        if (lat !== 2) begin
            errs++;
            $display("FAIL write_latency: got %0d cycles, required 2", lat);
        end
        checks++;
        if (busy_a !== 1'b0 || rdata_a !== 32'h0) begin
            errs++;
            $display("FAIL write_after: busy=%b rdata=%h, required busy 0 rdata 0", busy_a, rdata_a);
        end
    endtask

    task automatic test_read;
        int lat;
        run_txn(1, 1'b1, 4'd1, 32'h4, 32'h0, lat);
        checks++;
        if (lat !== 2) begin
            errs++;
            $display("FAIL write_b_latency: got %0d cycles, required 2", lat);
        end
        run_txn(1, 1'b0, 4'd2, 32'h0, 32'h9, lat);
        checks++;
        if (lat !== 3) begin
            errs++;
            $display("FAIL read_latency: got %0d cycles, required 3", lat);
        end
        checks++;
        if (rdata_a !== 32'h9) begin
            errs++;
            $display("FAIL read_data: got %h, required 00000009", rdata_a);
        end
    endtask

    task automatic test_contention;
        int lat;
        int order [4];
        rst_a = 1'b1;
        @(posedge hal_clk);
        @(negedge hal_clk);
        rst_a = 1'b0;
        set_req(0, 1'b1, 4'd8, 32'h80, 32'h0);
        set_req(1, 1'b0, 4'd2, 32'h0, 32'h9);
        valid_a = 2'b11;
        wait_ack_a(0, lat);
        valid_a[0] = 1'b0;
        checks++;
        if (lat !== 2) begin
            errs++;
            $display("FAIL contention_first: req0 ack after %0d cycles, required 2", lat);
        end
        wait_ack_a(1, lat);
        valid_a[1] = 1'b0;
        checks++;
        if (lat !== 4) begin
            errs++;
            $display("FAIL contention_second: req1 ack after %0d cycles, required 4", lat);
        end
        @(negedge hal_clk);
        // Both held valid: acks must alternate 0,1,0,1.
        set_req(0, 1'b1, 4'd3, 32'h30, 32'h0);
        set_req(1, 1'b1, 4'd4, 32'h41, 32'h0);
        set_req(0, 1'b1, 4'd3, 32'h30, 32'h0);
        set_req(1, 1'b1, 4'd4, 32'h41, 32'h0);
        valid_a = 2'b11;
        for (int k = 0; k < 4; k++) begin
            order[k] = -1;
            for (int n = 0; n < 50; n++) begin
                @(posedge hal_clk);
                @(negedge hal_clk);
                if (ack_a != 2'b00) begin
                    order[k] = ack_a[1] ? 1 : 0;
                    break;
                end
            end
        end
        valid_a = 2'b00;
        @(negedge hal_clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (order[k] !== k % 2) begin
                errs++;
                $display("FAIL alternate_%0d: granted %0d, required %0d", k, order[k], k % 2);
            end
        end
    endtask

    task automatic test_fairness;
        int lat;
        set_req(0, 1'b1, 4'd6, 32'h60, 32'h0);
        set_req(1, 1'b1, 4'd5, 32'h51, 32'h0);
        valid_a = 2'b11;
        wait_ack_a(0, lat);
        checks++;
        if (lat !== 2) begin
            errs++;
            $display("FAIL fair_first: req0 ack after %0d cycles, required 2", lat);
        end
        // req0 stays valid as a fresh request; req1 must still win next.
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge hal_clk);
            @(negedge hal_clk);
            if (ack_a != 2'b00) begin
                lat = ack_a[1] ? n : -n;
                break;
            end
        end
        valid_a = 2'b00;
        checks++;
        if (lat !== 3) begin
            errs++;
            $display("FAIL fair_second: next ack code %0d (negative = req0), required req1 after 3", lat);
        end
        @(negedge hal_clk);
    endtask

    task automatic test_reset_in_wait;
        int lat;
        int seen;
        write_b = 2'b00; addr_b[3:0] = 4'd5;
        valid_b[0] = 1'b1;
        wait_ack_b(lat);
        valid_b[0] = 1'b0;
        checks++;
        if (lat !== 5 || rdata_b !== 32'h0ABC1235) begin
            errs++;
            $display("FAIL rl3_read: lat=%0d rdata=%h, required 5 and 0abc1235", lat, rdata_b);
        end
        @(negedge hal_clk);
        addr_b[3:0] = 4'd6;
        valid_b[0] = 1'b1;
        repeat (2) @(posedge hal_clk);
        @(negedge hal_clk);
        checks++;
        if (busy_b !== 1'b1 || ack_b !== 2'b00) begin
            errs++;
            $display("FAIL rl3_in_wait: busy=%b ack=%b, required busy 1 ack 00", busy_b, ack_b);
        end
        rst_b = 1'b1;
        valid_b[0] = 1'b0;
        @(posedge hal_clk);
        @(negedge hal_clk);
        rst_b = 1'b0;
        checks++;
        if (busy_b !== 1'b0 || rdata_b !== 32'h0 || ack_b !== 2'b00 || rd_b !== 1'b0 || wr_b !== 1'b0) begin
            errs++;
            $display("FAIL rl3_after_reset: busy=%b rdata=%h ack=%b rd=%b wr=%b, required all 0", busy_b, rdata_b, ack_b, rd_b, wr_b);
        end
        seen = 0;
        repeat (6) begin
            @(negedge hal_clk);
            if (ack_b != 2'b00 || busy_b) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errs++;
            $display("FAIL rl3_no_pending_ack: %0d busy/ack cycles, required 0", seen);
        end
        addr_b[3:0] = 4'd7;
        valid_b[0] = 1'b1;
        wait_ack_b(lat);
        valid_b[0] = 1'b0;
        checks++;
        if (lat !== 5 || rdata_b !== 32'h0ABC1237) begin
            errs++;
            $display("FAIL rl3_recover: lat=%0d rdata=%h, required 5 and 0abc1237", lat, rdata_b);
        end
    endtask

    task automatic test_adder;
        int lat;
        run_txn(0, 1'b1, 4'd0, 32'h3, 32'h0, lat);
        checks++;
        if (lat !== 2 || rdata_a !== 32'h9) begin
            errs++;
            $display("FAIL adder_write_a: lat=%0d rdata=%h, required 2 and unchanged 00000009", lat, rdata_a);
        end
        run_txn(1, 1'b1, 4'd1, 32'h4, 32'h0, lat);
        checks++;
        if (lat !== 2) begin
            errs++;
            $display("FAIL adder_write_b: lat=%0d, required 2", lat);
        end
        run_txn(0, 1'b0, 4'd2, 32'h0, 32'h7, lat);
        checks++;
        if (lat !== 3 || rdata_a !== 32'h7) begin
            errs++;
            $display("FAIL adder_sum: lat=%0d rdata=%h, required 3 and 00000007", lat, rdata_a);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_fairness();
        test_reset_in_wait();
        test_adder();
        repeat (3) @(negedge hal_clk);
        checks++;
        if (sb_q.size() != 0 || hal_q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d acks and %0d strobes outstanding, required 0 and 0", sb_q.size(), hal_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
